// File: rtl/mem_pkg.sv
// Shared encodings for the memory-access stage: access-type fields, bus size codes,
// exception codes and the bus FSM states.
package mem_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_W  = 7;

  // MemReadType[1:0] = size, MemReadType[2] = zero-extend
  localparam int unsigned MRT_ZEXT = 2;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [2:0] EXC_NONE = 3'b000;
  localparam logic [2:0] EXC_ADEL = 3'b100;
  localparam logic [2:0] EXC_ADES = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/load_align.sv
// Load data lane select plus sign/zero extension.
module load_align
  import mem_pkg::*;
(
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [1:0]        addr_i,
  input  logic [2:0]        mem_read_type_i,
  output logic [DATA_W-1:0] data_o
);

  logic [7:0]  byte_c;
  logic [15:0] half_c;
  logic        sext_c;

  always_comb begin
    sext_c = ~mem_read_type_i[MRT_ZEXT];
    case (addr_i)
      2'd0:    byte_c = rdata_i[7:0];
      2'd1:    byte_c = rdata_i[15:8];
      2'd2:    byte_c = rdata_i[23:16];
      default: byte_c = rdata_i[31:24];
    endcase
    half_c = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (mem_read_type_i[1:0])
      SIZE_BYTE: data_o = {{24{sext_c & byte_c[7]}}, byte_c};
      SIZE_HALF: data_o = {{16{sext_c & half_c[15]}}, half_c};
      default:   data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: drives an SRAM-like data bus, stalls the pipeline while
// the bus is busy, aligns load data and flags misaligned addresses.
module mem_access
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              flush,
  input  logic              MemRead_i,
  input  logic              MemWrite_i,
  input  logic [2:0]        MemReadType_i,
  input  logic              RegWrite_i,
  input  logic              MemtoReg_i,
  input  logic [ADDR_W-1:0] ALUResult_i,
  input  logic [DATA_W-1:0] MemData_i,
  input  logic [REG_W-1:0]  WriteRegister_i,
  input  logic [ADDR_W-1:0] PCin,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              stall,
  output logic              RegWrite_o,
  output logic              MemtoReg_o,
  output logic [DATA_W-1:0] ReadData,
  output logic [ADDR_W-1:0] ALUResult_o,
  output logic [REG_W-1:0]  WriteRegister_o,
  output logic [ADDR_W-1:0] PCout,
  output logic [2:0]        exception,
  output logic [ADDR_W-1:0] BadVAddr
);

  state_e            state_q;
  logic              killed_q;
  logic [DATA_W-1:0] read_data_q;
  logic              wr_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [2:0]        type_q;

  logic              mem_op_c;
  logic              misaligned_c;
  logic              start_c;
  logic              busy_c;
  logic [1:0]        size_c;
  logic [DATA_W-1:0] wdata_c;
  logic [DATA_W-1:0] aligned_c;

  load_align u_load_align (
    .rdata_i         (data_rdata),
    .addr_i          (addr_q[1:0]),
    .mem_read_type_i (type_q),
    .data_o          (aligned_c)
  );

  // Decode the access in EX/MEM; bus fields come from the inputs only while IDLE,
  // afterwards from the copy latched at issue so a flush cannot disturb a held request.
  always_comb begin
    mem_op_c = MemRead_i | MemWrite_i;
    size_c   = MemReadType_i[1] ? SIZE_WORD : MemReadType_i[1:0];
    case (size_c)
      SIZE_BYTE: begin
        misaligned_c = 1'b0;
        wdata_c      = {4{MemData_i[7:0]}};
      end
      SIZE_HALF: begin
        misaligned_c = ALUResult_i[0];
        wdata_c      = {2{MemData_i[15:0]}};
      end
      default: begin
        misaligned_c = |ALUResult_i[1:0];
        wdata_c      = MemData_i;
      end
    endcase

    start_c = !rst && (state_q == IDLE) && valid_i && mem_op_c && !misaligned_c && !flush;
    busy_c  = !rst && ((state_q == REQ) || (state_q == DATA));

    data_req   = start_c || (!rst && (state_q == REQ));
    stall      = start_c || busy_c;
    data_wr    = (state_q == IDLE) ? MemWrite_i  : wr_q;
    data_size  = (state_q == IDLE) ? size_c      : size_q;
    data_addr  = (state_q == IDLE) ? ALUResult_i : addr_q;
    data_wdata = (state_q == IDLE) ? wdata_c     : wdata_q;

    exception = EXC_NONE;
    BadVAddr  = '0;
    if (!rst && (state_q == IDLE) && valid_i && mem_op_c && misaligned_c && !flush) begin
      exception = MemRead_i ? EXC_ADEL : EXC_ADES;
      BadVAddr  = ALUResult_i;
    end

    RegWrite_o      = !rst && RegWrite_i && valid_i && !flush && !killed_q
                      && (exception == EXC_NONE);
    MemtoReg_o      = MemtoReg_i;
    ALUResult_o     = ALUResult_i;
    WriteRegister_o = WriteRegister_i;
    PCout           = PCin;
    ReadData        = read_data_q;
  end

  // Bus FSM; a data_ok seen while still waiting for addr_ok is ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      killed_q    <= 1'b0;
      read_data_q <= '0;
      wr_q        <= 1'b0;
      size_q      <= SIZE_BYTE;
      addr_q      <= '0;
      wdata_q     <= '0;
      type_q      <= 3'b000;
    end else begin
      case (state_q)
        IDLE: begin
          killed_q <= 1'b0;
          if (start_c) begin
            wr_q    <= MemWrite_i;
            size_q  <= size_c;
            addr_q  <= ALUResult_i;
            wdata_q <= wdata_c;
            type_q  <= MemReadType_i;
            state_q <= data_addr_ok ? DATA : REQ;
          end
        end
        REQ: begin
          if (flush) killed_q <= 1'b1;
          if (data_addr_ok) state_q <= DATA;
        end
        DATA: begin
          if (flush) killed_q <= 1'b1;
          if (data_data_ok) begin
            if (killed_q || flush) begin
              killed_q <= 1'b0;
              state_q  <= IDLE;
            end else begin
              if (!wr_q) read_data_q <= aligned_c;
              state_q <= DONE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access with hand-computed expectations.
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i, flush, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i;
  logic [2:0]  MemReadType_i;
  logic [31:0] ALUResult_i, MemData_i, PCin;
  logic [6:0]  WriteRegister_i;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        stall, RegWrite_o, MemtoReg_o;
  logic [31:0] ReadData, ALUResult_o, PCout, BadVAddr;
  logic [6:0]  WriteRegister_o;
  logic [2:0]  exception;

  int n_checks = 0;
  int n_fail   = 0;
  int stalls;
  int done_c;

  always #5 clk = ~clk;

  mem_access dut (
    .clk             (clk),
    .rst             (rst),
    .valid_i         (valid_i),
    .flush           (flush),
    .MemRead_i       (MemRead_i),
    .MemWrite_i      (MemWrite_i),
    .MemReadType_i   (MemReadType_i),
    .RegWrite_i      (RegWrite_i),
    .MemtoReg_i      (MemtoReg_i),
    .ALUResult_i     (ALUResult_i),
    .MemData_i       (MemData_i),
    .WriteRegister_i (WriteRegister_i),
    .PCin            (PCin),
    .data_req        (data_req),
    .data_wr         (data_wr),
    .data_size       (data_size),
    .data_addr       (data_addr),
    .data_wdata      (data_wdata),
    .data_addr_ok    (data_addr_ok),
    .data_data_ok    (data_data_ok),
    .data_rdata      (data_rdata),
    .stall           (stall),
    .RegWrite_o      (RegWrite_o),
    .MemtoReg_o      (MemtoReg_o),
    .ReadData        (ReadData),
    .ALUResult_o     (ALUResult_o),
    .WriteRegister_o (WriteRegister_o),
    .PCout           (PCout),
    .exception       (exception),
    .BadVAddr        (BadVAddr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Plays the bus side: addr_ok in cycle addr_dly, data_ok data_dly cycles later.
  // Returns at the first cycle with stall low (without advancing past it).
  task automatic run_bus(input int addr_dly, input int data_dly, input logic [31:0] rdata,
                         input logic [31:0] exp_addr, output int n_stall, output int done_at);
    bit got = 1'b0;
    bit fin = 1'b0;
    int ac  = 0;
    n_stall = 0;
    done_at = -1;
    for (int c = 0; c < 30 && !fin; c++) begin
      data_addr_ok = !got && (c == addr_dly);
      data_data_ok = got && (c == ac + data_dly);
      data_rdata   = data_data_ok ? rdata : 32'h0;
      #1;
      if (!stall) begin
        done_at = c;
        fin     = 1'b1;
      end else begin
        n_stall++;
        if (!got) begin
          chk("req_held", 32'(data_req), 32'd1);
          chk("addr_held", data_addr, exp_addr);
        end
        if (data_addr_ok) begin
          got = 1'b1;
          ac  = c;
        end
        tick;
      end
    end
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata   = 32'h0;
    chk("bus_timeout", 32'(fin), 32'd1);
  endtask

  initial begin
    // Reset with a misaligned load presented: every gated output must stay low.
    rst = 1'b1; valid_i = 1'b1; flush = 1'b0; MemRead_i = 1'b1; MemWrite_i = 1'b0;
    MemReadType_i = 3'b010; RegWrite_i = 1'b1; MemtoReg_i = 1'b1; ALUResult_i = 32'h6;
    MemData_i = 32'h0; WriteRegister_i = 7'd5; PCin = 32'h0;
    data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
    tick; tick;
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_exc", 32'(exception), 32'd0);
    chk("rst_badv", BadVAddr, 32'd0);
    chk("rst_regwr", 32'(RegWrite_o), 32'd0);
    chk("rst_rdata", ReadData, 32'd0);

    rst = 1'b0; valid_i = 1'b0;
    tick;

    // LB from 0x3, byte 0x80 -> sign-extended
    valid_i = 1'b1; MemRead_i = 1'b1; MemWrite_i = 1'b0; MemReadType_i = 3'b000;
    ALUResult_i = 32'h3; RegWrite_i = 1'b1; MemtoReg_i = 1'b1;
    #1;
    chk("lb_req", 32'(data_req), 32'd1);
    chk("lb_size", 32'(data_size), 32'd0);
    chk("lb_wr", 32'(data_wr), 32'd0);
    run_bus(0, 1, 32'h80AA_BBCC, 32'h3, stalls, done_c);
    chk("lb_stalls", 32'(stalls), 32'd2);
    chk("lb_done", 32'(done_c), 32'd2);
    chk("lb_data", ReadData, 32'hFFFF_FF80);
    chk("lb_regwr", 32'(RegWrite_o), 32'd1);
    tick;

    // LBU same access -> zero-extended
    MemReadType_i = 3'b100;
    run_bus(0, 1, 32'h80AA_BBCC, 32'h3, stalls, done_c);
    chk("lbu_stalls", 32'(stalls), 32'd2);
    chk("lbu_data", ReadData, 32'h0000_0080);
    tick;

    // SH 0x12345678 to 0x2 -> halfword replicated
    MemRead_i = 1'b0; MemWrite_i = 1'b1; MemReadType_i = 3'b001; ALUResult_i = 32'h2;
    MemData_i = 32'h1234_5678; RegWrite_i = 1'b0; MemtoReg_i = 1'b0;
    #1;
    chk("sh_req", 32'(data_req), 32'd1);
    chk("sh_size", 32'(data_size), 32'd1);
    chk("sh_wdata", data_wdata, 32'h5678_5678);
    chk("sh_wr", 32'(data_wr), 32'd1);
    run_bus(0, 1, 32'h0, 32'h2, stalls, done_c);
    chk("sh_stalls", 32'(stalls), 32'd2);
    chk("sh_done", 32'(done_c), 32'd2);
    chk("sh_keep_rdata", ReadData, 32'h0000_0080);
    tick;

    // LW from 0x6 -> AdEL, no request
    MemRead_i = 1'b1; MemWrite_i = 1'b0; MemReadType_i = 3'b010; ALUResult_i = 32'h6;
    RegWrite_i = 1'b1;
    #1;
    chk("adel_req", 32'(data_req), 32'd0);
    chk("adel_exc", 32'(exception), 32'b100);
    chk("adel_badv", BadVAddr, 32'h6);
    chk("adel_regwr", 32'(RegWrite_o), 32'd0);
    chk("adel_stall", 32'(stall), 32'd0);
    tick;

    // SH to 0x1001 -> AdES
    MemRead_i = 1'b0; MemWrite_i = 1'b1; MemReadType_i = 3'b001; ALUResult_i = 32'h1001;
    RegWrite_i = 1'b0;
    #1;
    chk("ades_req", 32'(data_req), 32'd0);
    chk("ades_exc", 32'(exception), 32'b101);
    chk("ades_badv", BadVAddr, 32'h1001);
    tick;

    // LH from 0x102 with addr_ok delayed 3 and data_ok 2 later
    MemRead_i = 1'b1; MemWrite_i = 1'b0; MemReadType_i = 3'b001; ALUResult_i = 32'h102;
    RegWrite_i = 1'b1;
    run_bus(3, 2, 32'h8001_1234, 32'h102, stalls, done_c);
    chk("dly_stalls", 32'(stalls), 32'd6);
    chk("dly_done", 32'(done_c), 32'd6);
    chk("dly_data", ReadData, 32'hFFFF_8001);
    tick;

    // LW from 0x10 flushed while in DATA: drain, no DONE, result discarded
    MemReadType_i = 3'b010; ALUResult_i = 32'h10; data_addr_ok = 1'b1;
    #1;
    chk("fl_stall0", 32'(stall), 32'd1);
    tick;
    data_addr_ok = 1'b0; flush = 1'b1; data_rdata = 32'hDEAD_BEEF;
    #1;
    chk("fl_stall1", 32'(stall), 32'd1);
    chk("fl_regwr1", 32'(RegWrite_o), 32'd0);
    tick;
    flush = 1'b0;
    #1;
    chk("fl_stall2", 32'(stall), 32'd1);
    chk("fl_regwr2", 32'(RegWrite_o), 32'd0);
    tick;
    data_data_ok = 1'b1;
    #1;
    chk("fl_stall3", 32'(stall), 32'd1);
    chk("fl_regwr3", 32'(RegWrite_o), 32'd0);
    tick;
    data_data_ok = 1'b0; data_rdata = 32'h0;
    chk("fl_discard", ReadData, 32'hFFFF_8001);
    ALUResult_i = 32'h20;
    run_bus(0, 1, 32'hCAFE_F00D, 32'h20, stalls, done_c);
    chk("fl_next_stalls", 32'(stalls), 32'd2);
    chk("fl_next_data", ReadData, 32'hCAFE_F00D);
    chk("fl_next_regwr", 32'(RegWrite_o), 32'd1);
    tick;

    // Non-memory op passes straight through
    MemRead_i = 1'b0; MemWrite_i = 1'b0; RegWrite_i = 1'b1; MemtoReg_i = 1'b0;
    ALUResult_i = 32'hA5A5_0001; WriteRegister_i = 7'h55; PCin = 32'h0040_0000;
    #1;
    chk("alu_stall", 32'(stall), 32'd0);
    chk("alu_req", 32'(data_req), 32'd0);
    chk("alu_regwr", 32'(RegWrite_o), 32'd1);
    chk("alu_result", ALUResult_o, 32'hA5A5_0001);
    chk("alu_wreg", 32'(WriteRegister_o), 32'h55);
    chk("alu_pc", PCout, 32'h0040_0000);
    chk("alu_m2r", 32'(MemtoReg_o), 32'd0);
    tick;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
